// File: rtl/minmax_pkg.sv
// Shared definitions for the windowed min/max tracker: FSM state encoding and
// the width helper for the sample-count output.
package minmax_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic int cw_of(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/minmax_window_cmp.sv
// Combinational N-bit magnitude compare (lt/gt/eq of a against b).
// Define MINMAX_SIGNED_EN to treat both operands as two's-complement.
module minmax_cmp #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt,
  output logic         gt,
  output logic         eq
);

`ifdef MINMAX_SIGNED_EN
  logic signed [N-1:0] sa;
  logic signed [N-1:0] sb;

  assign sa = a;
  assign sb = b;
  assign lt = (sa < sb);
  assign gt = (sa > sb);
`else
  assign lt = (a < b);
  assign gt = (a > b);
`endif
  assign eq = (a == b);

endmodule

// File: rtl/minmax_window.sv
// Windowed streaming min/max tracker: emits min, max, count and all-equal per
// WINDOW samples or on an early flush. MINMAX_SIGNED_EN selects signed compare.
module minmax_window
  import minmax_pkg::*;
#(
  parameter  int N      = 32,
  parameter  int WINDOW = 8,
  localparam int CW     = cw_of(WINDOW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_min,
  output logic [N-1:0]  out_max,
  output logic [CW-1:0] out_count,
  output logic          out_all_equal
);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] upd_cnt;
  logic [N-1:0]  run_min_p0;
  logic [N-1:0]  run_max_p0;
  logic [N-1:0]  upd_min;
  logic [N-1:0]  upd_max;
  logic          acc;
  logic          close;
  logic          lt_min;
  logic          gt_max;
  logic          cmp_unused_gt_min;
  logic          cmp_unused_eq_min;
  logic          cmp_unused_lt_max;
  logic          cmp_unused_eq_max;

  minmax_cmp #(.N(N)) u_cmp_min (
    .a  (in_data),
    .b  (run_min_p0),
    .lt (lt_min),
    .gt (cmp_unused_gt_min),
    .eq (cmp_unused_eq_min)
  );

  minmax_cmp #(.N(N)) u_cmp_max (
    .a  (in_data),
    .b  (run_max_p0),
    .lt (cmp_unused_lt_max),
    .gt (gt_max),
    .eq (cmp_unused_eq_max)
  );

  assign acc       = in_valid && in_ready;
  assign out_valid = (state == ST_HOLD);

  always_comb begin
    upd_min   = run_min_p0;
    upd_max   = run_max_p0;
    upd_cnt   = cnt;
    state_nxt = state;
    close     = 1'b0;

    if (acc) begin
      if (state == ST_EMPTY) begin
        upd_min = in_data;
        upd_max = in_data;
        upd_cnt = CW'(1);
      end else begin
        if (lt_min) upd_min = in_data;
        if (gt_max) upd_max = in_data;
        upd_cnt = cnt + 1'b1;
      end
    end

    case (state)
      ST_EMPTY: if (acc) state_nxt = (upd_cnt == CW'(WINDOW)) ? ST_HOLD : ST_ACCUM;
      ST_ACCUM: if ((acc && (upd_cnt == CW'(WINDOW))) || flush) state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase

    close = (state != ST_HOLD) && (state_nxt == ST_HOLD);

    if (clear) begin
      state_nxt = ST_EMPTY;
      close     = 1'b0;
    end
  end

  // control: state, count and the registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      cnt      <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_HOLD);
      cnt      <= (clear || close) ? '0 : upd_cnt;
    end
  end

  // running extrema are reloaded by the first sample of every window
  always_ff @(posedge clk) begin
    if (acc) begin
      run_min_p0 <= upd_min;
      run_max_p0 <= upd_max;
    end
  end

  // result beat: loads from the post-update values at window close
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_min       <= '0;
      out_max       <= '0;
      out_count     <= '0;
      out_all_equal <= 1'b0;
    end else if (clear) begin
      out_min       <= '0;
      out_max       <= '0;
      out_count     <= '0;
      out_all_equal <= 1'b0;
    end else if (close) begin
      out_min       <= upd_min;
      out_max       <= upd_max;
      out_count     <= upd_cnt;
      out_all_equal <= (upd_min == upd_max);
    end
  end

endmodule
